measurement_stream_unpacker: RTL
================================

# measurement_stream_unpacker

Parses the 8-bit host byte stream arriving from the input FIFO and turns it into one parallel syndrome word per measurement round for the decoder core. It sits between the input `fifo_wrapper` output and the measurement input of the decoder core. It recognises the start-decoding and measurement-data header bytes, strips per-round byte padding, and presents each round with a valid/ready handshake, tagged with its round index.

## Interface

Parameters:
- `GRID_WIDTH_X`, default 4: PU columns per round.
- `GRID_WIDTH_Z`, default 1: PU rows per round.
- `GRID_WIDTH_U`, default 5: rounds per measurement block.
- `START_DECODING_MSG`, default 8'h01: session-start byte.
- `MEASUREMENT_DATA_HEADER`, default 8'h02: block-start byte.
- Derived `PU_PER_ROUND` = `GRID_WIDTH_X*GRID_WIDTH_Z`.
- Derived `BYTES_PER_ROUND` = (`PU_PER_ROUND`+7)>>3.
- Derived `U_BITS` = max(1, clog2(`GRID_WIDTH_U`)).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_data` in 8: byte from the input FIFO.
- `in_valid` in 1: byte valid.
- `in_ready` out 1: byte accepted when `in_valid & in_ready`.
- `round_data` out `PU_PER_ROUND`: syndrome bits of one round; bit `i*GRID_WIDTH_Z+j` is PU (x=i, z=j).
- `round_index` out `U_BITS`: round number within the block.
- `round_last` out 1: high with the final round of a block.
- `round_valid` out 1: round word valid.
- `round_ready` in 1: consumer accepts the round.
- `decode_start` out 1: one-cycle pulse when a start byte is accepted.
- `header_error` out 1: one-cycle pulse when an unexpected byte is dropped.
- `busy` out 1: high when the state is not IDLE.

## Operation

State machine with states IDLE, WAIT_HDR, COLLECT and PRESENT.

- **IDLE**: `in_ready`=1.
  - Accepted byte == `START_DECODING_MSG`: go to WAIT_HDR and pulse `decode_start`.
  - Any other byte: drop it, pulse `header_error`, stay in IDLE.
- **WAIT_HDR**: `in_ready`=1.
  - `MEASUREMENT_DATA_HEADER`: clear `byte_cnt` and `round_cnt`, go to COLLECT.
  - `START_DECODING_MSG`: pulse `decode_start`, stay in WAIT_HDR.
  - Any other byte: pulse `header_error`, stay in WAIT_HDR.
- **COLLECT**: `in_ready`=1.
  - Accepted byte b (b = `byte_cnt`) is written to assembly bits [8b+7:8b]. Byte ordering is little-endian, so stream byte k·`BYTES_PER_ROUND`+b belongs to round k.
  - When `byte_cnt` == `BYTES_PER_ROUND`-1: load the output register with assembly bits [`PU_PER_ROUND`-1:0], reset `byte_cnt` to 0, go to PRESENT.
  - Padding bits above `PU_PER_ROUND` are discarded.
  - Header values carry no special meaning in COLLECT; every byte is data.
- **PRESENT**: `in_ready`=0, `round_valid`=1.
  - `round_index` = `round_cnt`.
  - `round_last` = (`round_cnt` == `GRID_WIDTH_U`-1).
  - On `round_ready`: if `round_last`, go to WAIT_HDR; otherwise increment `round_cnt` and go to COLLECT.
- `round_data`, `round_index` and `round_last` are registered and stable throughout PRESENT.

## Timing

- Reset values:
  - State IDLE.
  - `round_valid`, `round_last`, `decode_start`, `header_error` = 0.
  - `round_data` = 0, `round_index` = 0.
  - `in_ready` = 1 (IDLE).
  - `busy` = 0.
- `in_ready` is decoded combinationally from state only; it never depends on `in_valid`.
- Latency: the last byte of a round is accepted at edge N; `round_valid` is high from cycle N+1.
- Throughput: `BYTES_PER_ROUND`+1 cycles per round minimum.
- `round_valid` deasserts in the cycle after the handshake edge.
- `decode_start` and `header_error` are registered and last exactly one cycle.
- Backpressure: while `round_ready`=0, the unpacker holds all round outputs and keeps `in_ready`=0, with no loss or duplication.
- `in_valid`=0 in COLLECT stalls the round without corrupting the bytes already collected.
- Reset during COLLECT or PRESENT: the next cycle is IDLE, partial data is discarded, and no `round_valid` is issued.

## Test plan

1. **Nominal block.** Defaults (4×1×5); stream 01, 02, 05, 0A, 0F, 00, 03 with `round_ready`=1.
   - One `decode_start` pulse.
   - `round_data` = 5, A, F, 0, 3 with `round_index` 0..4.
   - `round_last` only on index 4; state ends in WAIT_HDR.
2. **Backpressure.** Hold `round_ready`=0 for 3 cycles during round 1 of scenario 1.
   - `round_data`=A is held for 4 cycles and `in_ready`=0 throughout.
   - Next byte is accepted only after the handshake; the output sequence is unchanged.
3. **Padding and protocol errors.**
   - Byte F5 as a round byte gives `round_data`=4'h5.
   - 7E in IDLE gives one `header_error` pulse and the state stays IDLE.
   - 01 in WAIT_HDR gives a `decode_start` pulse and the state stays WAIT_HDR.
4. **Back-to-back blocks.** After block 1, send 02 plus 5 round bytes without a new 01.
   - Second block is emitted with `round_index` restarting at 0.
5. **Multi-byte rounds.** GRID_WIDTH_X=6, GRID_WIDTH_Z=2, GRID_WIDTH_U=3; bytes 34,12 / FF,FF / 00,08.
   - `round_data` = 12'h234, 12'hFFF, 12'h800.
6. **Reset mid-round.** Assert `reset` after the first byte of a two-byte round.
   - Outputs return to reset values and the state is IDLE.
   - A fresh 01, 02, ... stream then decodes correctly.

Source files
------------

// File: rtl/measurement_stream_unpacker.sv
// measurement_stream_unpacker
//
// Turns the 8-bit host byte stream from the input FIFO into one parallel
// syndrome word per measurement round for the decoder core. A start byte
// opens a session. A measurement-data header byte opens a block of
// GRID_WIDTH_U rounds. Each round arrives as BYTES_PER_ROUND little-endian
// bytes, and the padding bits above PU_PER_ROUND are dropped.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   in_data        byte from the input FIFO
//   in_valid       byte valid
//   in_ready       byte accepted when in_valid & in_ready (decoded from state only)
//   round_data     syndrome bits of one round, bit i*GRID_WIDTH_Z+j = PU (x=i, z=j)
//   round_index    round number within the block
//   round_last     high with the final round of a block
//   round_valid    round word valid
//   round_ready    consumer accepts the round
//   decode_start   one-cycle pulse when a start byte is accepted
//   header_error   one-cycle pulse when an unexpected byte is dropped
//   busy           high whenever the state is not IDLE
module measurement_stream_unpacker #(
  parameter int         GRID_WIDTH_X            = 4,
  parameter int         GRID_WIDTH_Z            = 1,
  parameter int         GRID_WIDTH_U            = 5,
  parameter logic [7:0] START_DECODING_MSG      = 8'h01,
  parameter logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02,
  localparam int        PU_PER_ROUND            = GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int        BYTES_PER_ROUND         = (PU_PER_ROUND + 7) >> 3,
  localparam int        U_BITS                  = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [PU_PER_ROUND-1:0] round_data,
  output logic [U_BITS-1:0]       round_index,
  output logic                    round_last,
  output logic                    round_valid,
  input  logic                    round_ready,
  output logic                    decode_start,
  output logic                    header_error,
  output logic                    busy
);

  localparam int                 BC_BITS    = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;
  localparam logic [BC_BITS-1:0] LAST_BYTE  = BC_BITS'(BYTES_PER_ROUND - 1);
  localparam logic [U_BITS-1:0]  LAST_ROUND = U_BITS'(GRID_WIDTH_U - 1);

  typedef enum logic [1:0] {IDLE, WAIT_HDR, COLLECT, PRESENT} state_t;

  state_t                  state, state_next;
  logic [BC_BITS-1:0]      byte_cnt;
  logic [U_BITS-1:0]       round_cnt;
  logic [PU_PER_ROUND-1:0] assembly, assembly_next;
  logic                    accept;
  logic                    start_block, load_round, advance_round;
  logic                    decode_start_next, header_error_next;

  assign in_ready    = (state != PRESENT);
  assign round_valid = (state == PRESENT);
  assign busy        = (state != IDLE);
  assign accept      = in_valid & in_ready;

  always_comb begin
    state_next        = state;
    decode_start_next = 1'b0;
    header_error_next = 1'b0;
    start_block       = 1'b0;
    load_round        = 1'b0;
    advance_round     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_data == START_DECODING_MSG) begin
            state_next        = WAIT_HDR;
            decode_start_next = 1'b1;
          end else begin
            header_error_next = 1'b1;
          end
        end
      end
      WAIT_HDR: begin
        if (accept) begin
          if (in_data == MEASUREMENT_DATA_HEADER) begin
            start_block = 1'b1;
            state_next  = COLLECT;
          end else if (in_data == START_DECODING_MSG) begin
            decode_start_next = 1'b1;
          end else begin
            header_error_next = 1'b1;
          end
        end
      end
      COLLECT: begin
        // Header values are plain data here; only the byte count matters.
        if (accept && (byte_cnt == LAST_BYTE)) begin
          load_round = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (round_ready) begin
          advance_round = ~round_last;
          state_next    = round_last ? WAIT_HDR : COLLECT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Merge the incoming byte into its slot. Only PU_PER_ROUND bits are kept,
  // so padding bits of the final byte simply have nowhere to land.
  always_comb begin
    assembly_next = assembly;
    for (int i = 0; i < PU_PER_ROUND; i++) begin
      if (byte_cnt == BC_BITS'(i / 8)) begin
        assembly_next[i] = in_data[i % 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt     <= '0;
      round_cnt    <= '0;
      assembly     <= '0;
      round_data   <= '0;
      round_index  <= '0;
      round_last   <= 1'b0;
      decode_start <= 1'b0;
      header_error <= 1'b0;
    end else begin
      decode_start <= decode_start_next;
      header_error <= header_error_next;
      if (start_block) begin
        byte_cnt  <= '0;
        round_cnt <= '0;
      end
      if ((state == COLLECT) && accept) begin
        assembly <= assembly_next;
        byte_cnt <= load_round ? '0 : byte_cnt + 1'b1;
      end
      // The last byte goes straight to the output register with the rest.
      if (load_round) begin
        round_data  <= assembly_next;
        round_index <= round_cnt;
        round_last  <= (round_cnt == LAST_ROUND);
      end
      if (advance_round) begin
        round_cnt <= round_cnt + 1'b1;
      end
    end
  end

endmodule
